matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer_if.sv | 33 +++
 rtl/matmul_sequencer.sv | 113 +++++++++++
 tb/tb_matmul_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/matmul_sequencer_if.sv
// Handshake and address bundle between the matmul sequencer and its operand/result buffers.
// Widths derive from the same M/N1/N2 parameters as the sequencer instance.
interface matmul_sequencer_if #(
    parameter int N1 = 4,
    parameter int N2 = 4,
    parameter int M  = 8
);
    localparam int AWA = (M * M / N1 > 1) ? $clog2(M * M / N1) : 1;
    localparam int AWB = (M * M / N2 > 1) ? $clog2(M * M / N2) : 1;
    localparam int RW  = (N1 > 1) ? $clog2(N1) : 1;

    logic           start;
    logic           stall;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic           clear_acc;
    logic [AWA-1:0] rd_addr_A;
    logic [AWB-1:0] rd_addr_B;
    logic           wr_en;
    logic [RW-1:0]  wr_row;
    logic [AWB-1:0] wr_addr;

    modport slave (
        input  start, stall,
        output busy, done, rd_en, clear_acc, rd_addr_A, rd_addr_B, wr_en, wr_row, wr_addr
    );

    modport master (
        output start, stall,
        input  busy, done, rd_en, clear_acc, rd_addr_A, rd_addr_B, wr_en, wr_row, wr_addr
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Tile sequencer for an N1xN2 systolic array computing an MxM product: stream K operands,
// drain the array skew, then write back N1 result rows per tile, slice_B innermost.
module matmul_sequencer #(
    parameter int N1 = 4,
    parameter int N2 = 4,
    parameter int M  = 8
) (
    input logic               clk,
    input logic               rst,
    matmul_sequencer_if.slave bus
);
    localparam int AWA      = (M * M / N1 > 1) ? $clog2(M * M / N1) : 1;
    localparam int AWB      = (M * M / N2 > 1) ? $clog2(M * M / N2) : 1;
    localparam int RW       = (N1 > 1) ? $clog2(N1) : 1;
    localparam int KW       = (M > 1) ? $clog2(M) : 1;
    localparam int SAW      = (M / N1 > 1) ? $clog2(M / N1) : 1;
    localparam int SBW      = (M / N2 > 1) ? $clog2(M / N2) : 1;
    localparam int DrainLen = N1 + N2 - 2;
    localparam int DW       = (DrainLen > 1) ? $clog2(DrainLen) : 1;

    typedef enum logic [2:0] {StIdle, StStream, StDrain, StWrite, StDone} state_e;

    state_e         state_q;
    logic [KW-1:0]  k_q;
    logic [DW-1:0]  dcnt_q;
    logic [RW-1:0]  row_q;
    logic [SAW-1:0] sa_q;
    logic [SBW-1:0] sb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            dcnt_q  <= '0;
            row_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StStream;
                        k_q     <= '0;
                        sa_q    <= '0;
                        sb_q    <= '0;
                    end
                end
                StStream: begin
                    if (!bus.stall) begin
                        if (k_q == KW'(M - 1)) begin
                            k_q     <= '0;
                            dcnt_q  <= '0;
                            row_q   <= '0;
                            state_q <= (DrainLen == 0) ? StWrite : StDrain;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (!bus.stall) begin
                        if (dcnt_q == DW'(DrainLen - 1)) begin
                            dcnt_q  <= '0;
                            row_q   <= '0;
                            state_q <= StWrite;
                        end else begin
                            dcnt_q <= dcnt_q + DW'(1);
                        end
                    end
                end
                StWrite: begin
                    if (!bus.stall) begin
                        if (row_q == RW'(N1 - 1)) begin
                            row_q <= '0;
                            // slice_B is the inner loop; both wrapping means the last tile is out
                            if (sb_q == SBW'(M / N2 - 1)) begin
                                sb_q <= '0;
                                if (sa_q == SAW'(M / N1 - 1)) begin
                                    sa_q    <= '0;
                                    state_q <= StDone;
                                end else begin
                                    sa_q    <= sa_q + SAW'(1);
                                    state_q <= StStream;
                                end
                            end else begin
                                sb_q    <= sb_q + SBW'(1);
                                state_q <= StStream;
                            end
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    logic rd_go;
    assign rd_go = (state_q == StStream) && !bus.stall;

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.rd_en     = rd_go;
    assign bus.clear_acc = rd_go && (k_q == '0);
    assign bus.wr_en     = (state_q == StWrite) && !bus.stall;
    assign bus.wr_row    = row_q;

    assign bus.rd_addr_A = AWA'(k_q) + AWA'(sa_q) * AWA'(M);
    assign bus.rd_addr_B = AWB'(k_q) + AWB'(sb_q) * AWB'(M);
    assign bus.wr_addr   = (AWB'(sa_q) * AWB'(N1) + AWB'(row_q)) * AWB'(M / N2) + AWB'(sb_q);
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: M=8/N=4 and M=4/N=4 instances, per-cycle output
// comparison against a schedule derived from the tile loop description.
module tb_matmul_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    matmul_sequencer_if #(.N1(4), .N2(4), .M(8)) bus8 ();
    matmul_sequencer_if #(.N1(4), .N2(4), .M(4)) bus4 ();

    matmul_sequencer #(.N1(4), .N2(4), .M(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    matmul_sequencer #(.N1(4), .N2(4), .M(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    // {busy,done,rd_en,clear_acc,wr_en,3'b0,addr_A[7:0],addr_B[7:0],wr_row[3:0],wr_addr[3:0]}
    function automatic logic [31:0] obs(input int sel);
        if (sel == 1)
            return {bus8.busy, bus8.done, bus8.rd_en, bus8.clear_acc, bus8.wr_en, 3'b0,
                    8'(bus8.rd_addr_A), 8'(bus8.rd_addr_B), 4'(bus8.wr_row), 4'(bus8.wr_addr)};
        else
            return {bus4.busy, bus4.done, bus4.rd_en, bus4.clear_acc, bus4.wr_en, 3'b0,
                    8'(bus4.rd_addr_A), 8'(bus4.rd_addr_B), 4'(bus4.wr_row), 4'(bus4.wr_addr)};
    endfunction

    // Expected outputs at effective job cycle e (0 = first STREAM cycle).
    function automatic logic [31:0] model(input int m, input int n1, input int n2, input int e,
                                          input bit stalled);
        int   d     = n1 + n2 - 2;
        int   l     = m + d + n1;
        int   nb    = m / n2;
        int   total = (m / n1) * nb * l;
        int   k     = 0;
        int   row   = 0;
        int   sa    = 0;
        int   sb    = 0;
        int   tile, p, aa, ab, wa;
        logic busy  = 1'b0;
        logic done  = 1'b0;
        logic rd    = 1'b0;
        logic clr   = 1'b0;
        logic wr    = 1'b0;
        if (e < total) begin
            tile = e / l;
            p    = e % l;
            sa   = tile / nb;
            sb   = tile % nb;
            busy = 1'b1;
            if (p < m) begin
                k   = p;
                rd  = !stalled;
                clr = !stalled && (p == 0);
            end else if (p >= m + d) begin
                row = p - m - d;
                wr  = !stalled;
            end
        end else if (e == total) begin
            busy = 1'b1;
            done = 1'b1;
        end
        aa = k + sa * m;
        ab = k + sb * m;
        wa = (sa * n1 + row) * nb + sb;
        return {busy, done, rd, clr, wr, 3'b0, 8'(aa), 8'(ab), 4'(row), 4'(wa)};
    endfunction

    task automatic drive(input int sel, input logic st, input logic sl);
        if (sel == 1) begin
            bus8.start = st;
            bus8.stall = sl;
        end else begin
            bus4.start = st;
            bus4.stall = sl;
        end
    endtask

    task automatic run_job(input string name, input int sel, input int stall_at,
                           input int stall_len, input int xs0, input int xs1, input int abort_at);
        int m     = (sel == 1) ? 8 : 4;
        int tiles = (m / 4) * (m / 4);
        int total = tiles * (m + 6 + 4) + stall_len;
        int dones = 0;
        int clrs  = 0;
        int rds   = 0;
        int t_done = -1;
        int e;
        bit stalled;
        bit aborted = 1'b0;
        logic [31:0] o;

        @(negedge clk);
        drive(sel, 1'b1, 1'b0);
        #1;
        check({name, "_pre"}, obs(sel), 32'h0);
        for (int t = 0; t <= total + 3; t++) begin
            @(negedge clk);
            stalled = (stall_at >= 0) && (t >= stall_at) && (t < stall_at + stall_len);
            drive(sel, (t == xs0) || (t == xs1), stalled);
            if (t == abort_at) begin
                #1;
                rst = 1'b1;
                #1;
                check({name, "_abort_now"}, obs(sel), 32'h0);
                aborted = 1'b1;
                break;
            end
            #1;
            if (stall_at >= 0 && t >= stall_at + stall_len) e = t - stall_len;
            else if (stalled) e = stall_at;
            else e = t;
            o = obs(sel);
            check($sformatf("%s_c%0d", name, t), o, model(m, 4, 4, e, stalled));
            if (o[30]) begin
                dones++;
                t_done = t;
            end
            if (o[28] && o[29]) clrs++;
            if (o[29]) rds++;
        end
        drive(sel, 1'b0, 1'b0);
        if (aborted) begin
            repeat (2) begin
                @(negedge clk);
                #1;
                check({name, "_in_rst"}, obs(sel), 32'h0);
            end
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                #1;
                o = obs(sel);
                check($sformatf("%s_post%0d", name, i), o, 32'h0);
                if (o[30]) dones++;
            end
            check({name, "_dones"}, 32'(dones), 32'd0);
        end else begin
            check({name, "_dones"}, 32'(dones), 32'd1);
            check({name, "_done_at"}, 32'(t_done), 32'(total));
            check({name, "_clears"}, 32'(clrs), 32'(tiles));
            check({name, "_reads"}, 32'(rds), 32'(tiles * m));
        end
    endtask

    initial begin
        drive(1, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_m8", obs(1), 32'h0);
        check("rst_m4", obs(2), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_m8", obs(1), 32'h0);

        run_job("basic", 1, -1, 0, -1, -1, -1);
        run_job("stall", 1, 4, 3, -1, -1, -1);
        run_job("xstart", 1, -1, 0, 3, 72, -1);
        run_job("abort", 1, -1, 0, -1, -1, 51);
        run_job("restart", 1, -1, 0, -1, -1, -1);
        run_job("m4", 2, -1, 0, -1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
